// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and widths for the divider controller
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-stage divider request/result bundle
interface div_ctrl_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic               start;
    logic               signed_op;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               flush;
    logic               pipe_stall;
    logic               stall_req;
    logic               busy;
    logic               hilo_valid;
    logic [2*WIDTH-1:0] hilo_result;

    modport master (
        output start, signed_op, opa, opb, flush, pipe_stall,
        input  stall_req, busy, hilo_valid, hilo_result
    );

    modport slave (
        input  start, signed_op, opa, opb, flush, pipe_stall,
        output stall_req, busy, hilo_valid, hilo_result
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration on {rem,quo}
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Remainder stays below the divisor, so a WIDTH-bit difference cannot wrap when ge.
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvsr};
    assign diff    = shifted[WIDTH-1:0] - dvsr;
    assign rem_nx  = ge ? diff : shifted[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer with pipeline stall and hilo handoff
// Optional DIV_ZERO_FAST_EN: divide by zero skips the iterations and completes at T+1.
module div_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_ctrl_if.slave bus
);
    div_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem, quo, dvsr, rem_nx, quo_nx, q_fix, r_fix;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] result_q;
    logic               sign_q, sign_r, div_zero;
    logic               accept, last_step, fast_zero;
    logic               stall_req, busy, hilo_valid;

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign last_step = (cnt == CNT_W'(WIDTH-1));
    assign mag_a     = (bus.signed_op && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign mag_b     = (bus.signed_op && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (bus.opb == '0);
`else
    assign fast_zero = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .quo    (quo),
        .dvsr   (dvsr),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    // Divide by zero reports an all-ones quotient regardless of operand signs.
    assign q_fix = div_zero ? '1 : (sign_q ? -quo_nx : quo_nx);
    assign r_fix = sign_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = fast_zero ? DONE : BUSY;
                BUSY:    if (last_step) state_nx = DONE;
                DONE:    if (!bus.pipe_stall) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req  = accept || (state == BUSY);
        busy       = (state != IDLE);
        hilo_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= mag_a;
            dvsr     <= mag_b;
            sign_q   <= bus.signed_op && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            sign_r   <= bus.signed_op && bus.opa[WIDTH-1];
            div_zero <= (bus.opb == '0);
            if (fast_zero) begin
                result_q <= {bus.opa, {WIDTH{1'b1}}};
            end
        end else if (state == BUSY && !bus.flush) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                result_q <= {r_fix, q_fix};
            end
        end
    end

    assign bus.stall_req   = stall_req;
    assign bus.busy        = busy;
    assign bus.hilo_valid  = hilo_valid;
    assign bus.hilo_result = result_q;
endmodule
